// File: rtl/ybus_arb_pkg.sv
// Shared types for the Y-bus arbiter: FSM states, parity-sense encoding and the
// expected-parity helper used at grant time.
package ybus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest data word the parity helper accepts; narrower words are zero-extended,
  // which leaves the reduction XOR unchanged.
  localparam int MAX_DW = 256;

  function automatic logic exp_parity(input logic [MAX_DW-1:0] data, input logic partysel);
    return (partysel == PAR_EVEN) ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/ybus_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping N-1 to 0. Zero latency, no backpressure.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o = PW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/ybus_arbiter.sv
// Round-robin arbiter sharing one Y-side consumer among N writebuffers; grant and
// OREQ appear one edge after YREQ is sampled; the source is held via YACK until release.
module ybus_arbiter
  import ybus_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 PARTYSEL,
  input  logic [N-1:0]         YREQ,
  input  logic [N*DW-1:0]      YDATA,
  input  logic [N-1:0]         YPARITY,
  output logic [N-1:0]         YACK,
  output logic                 OREQ,
  output logic [DW-1:0]        ODATA,
  output logic                 OPARITY,
  output logic [$clog2(N)-1:0] OSRC,
  input  logic                 OACK,
  output logic                 PARERR,
  output logic [CW-1:0]        ERRCNT
);

  localparam int SW = $clog2(N);

  state_e         state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [SW-1:0]  osrc_q, osrc_d;
  logic [N-1:0]   yack_q, yack_d;
  logic           oreq_q, oreq_d;
  logic [DW-1:0]  odata_q, odata_d;
  logic           opar_q, opar_d;
  logic           parerr_q, parerr_d;
  logic [CW-1:0]  errcnt_q, errcnt_d;

  logic           pick_vld;
  logic [SW-1:0]  pick_idx;
  logic [DW-1:0]  pick_dat;
  logic           pick_par;
  logic           pick_bad;

  rr_picker #(
    .N  (N),
    .PW (SW)
  ) u_rr_picker (
    .req_i   (YREQ),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_dat = '0;
    pick_par = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == SW'(i)) begin
        pick_dat = YDATA[i*DW +: DW];
        pick_par = YPARITY[i];
      end
    end
    pick_bad = (pick_par != exp_parity(MAX_DW'(pick_dat), PARTYSEL));
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    osrc_d   = osrc_q;
    yack_d   = yack_q;
    oreq_d   = oreq_q;
    odata_d  = odata_q;
    opar_d   = opar_q;
    parerr_d = 1'b0;
    errcnt_d = errcnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          odata_d = pick_dat;
          opar_d  = pick_par;
          osrc_d  = pick_idx;
          oreq_d  = 1'b1;
          state_d = XFER;
          if (pick_bad) begin
            parerr_d = 1'b1;
            if (errcnt_q != {CW{1'b1}}) errcnt_d = errcnt_q + 1'b1;
          end
        end
      end
      XFER: begin
        // A source dropping YREQ here is ignored; only OACK ends this phase.
        if (OACK) begin
          oreq_d  = 1'b0;
          yack_d  = {{(N-1){1'b0}}, 1'b1} << osrc_q;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!OACK && !YREQ[osrc_q]) begin
          yack_d  = '0;
          ptr_d   = (osrc_q == SW'(N - 1)) ? '0 : osrc_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      osrc_q   <= '0;
      yack_q   <= '0;
      oreq_q   <= 1'b0;
      odata_q  <= '0;
      opar_q   <= 1'b0;
      parerr_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      osrc_q   <= osrc_d;
      yack_q   <= yack_d;
      oreq_q   <= oreq_d;
      odata_q  <= odata_d;
      opar_q   <= opar_d;
      parerr_q <= parerr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign YACK    = yack_q;
  assign OREQ    = oreq_q;
  assign ODATA   = odata_q;
  assign OPARITY = opar_q;
  assign OSRC    = osrc_q;
  assign PARERR  = parerr_q;
  assign ERRCNT  = errcnt_q;

endmodule

// File: tb/tb_ybus_arbiter.sv
// Bench for ybus_arbiter: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of the request/grant/ack/release protocol.
module tb_ybus_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int SW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              PARTYSEL;
  logic [N-1:0]      YREQ;
  logic [N*DW-1:0]   YDATA;
  logic [N-1:0]      YPARITY;
  logic [N-1:0]      YACK;
  logic              OREQ;
  logic [DW-1:0]     ODATA;
  logic              OPARITY;
  logic [SW-1:0]     OSRC;
  logic              OACK;
  logic              PARERR;
  logic [CW-1:0]     ERRCNT;

  ybus_arbiter #(.N(N), .DW(DW), .CW(CW)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .PARTYSEL (PARTYSEL),
    .YREQ     (YREQ),
    .YDATA    (YDATA),
    .YPARITY  (YPARITY),
    .YACK     (YACK),
    .OREQ     (OREQ),
    .ODATA    (ODATA),
    .OPARITY  (OPARITY),
    .OSRC     (OSRC),
    .OACK     (OACK),
    .PARERR   (PARERR),
    .ERRCNT   (ERRCNT)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  // Model state: who owns the consumer, whether the consumer has acked, rr pointer, error count.
  int            m_owner;
  bit            m_acked;
  int            m_ptr;
  int            m_cnt;
  logic          e_oreq;
  logic [N-1:0]  e_yack;
  logic [DW-1:0] e_odata;
  logic          e_opar;
  int            e_osrc;
  logic          e_parerr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parity bit a well-behaved writebuffer would send for this word.
  function automatic logic good_par(input logic [DW-1:0] d, input logic sel);
    return logic'($countones(d) % 2) ^ sel;
  endfunction

  task automatic model_step();
    if (HRESET) begin
      m_owner = -1; m_acked = 0; m_ptr = 0; m_cnt = 0;
      e_oreq = 0; e_yack = '0; e_odata = '0; e_opar = 0; e_osrc = 0; e_parerr = 0;
      return;
    end
    e_parerr = 0;
    if (m_owner < 0) begin
      if (YREQ != '0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && YREQ[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_acked = 0;
        e_oreq  = 1;
        e_osrc  = m_owner;
        e_odata = YDATA[m_owner*DW +: DW];
        e_opar  = YPARITY[m_owner];
        if (good_par(e_odata, PARTYSEL) !== e_opar) begin
          e_parerr = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
    end else if (!m_acked) begin
      if (OACK) begin
        m_acked = 1;
        e_oreq  = 0;
        e_yack  = '0;
        e_yack[m_owner] = 1'b1;
      end
    end else if (!OACK && !YREQ[m_owner]) begin
      e_yack  = '0;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_acked = 0;
    end
  endtask

  task automatic check_all();
    chk("oreq", 64'(OREQ), 64'(e_oreq));
    chk("yack", 64'(YACK), 64'(e_yack));
    chk("parerr", 64'(PARERR), 64'(e_parerr));
    chk("errcnt", 64'(ERRCNT), 64'(m_cnt));
    chk("yack_onehot", 64'($countones(YACK) <= 1), 64'(1));
    if (e_oreq) begin
      chk("odata", 64'(ODATA), 64'(e_odata));
      chk("osrc", 64'(OSRC), 64'(e_osrc));
      chk("oparity", 64'(OPARITY), 64'(e_opar));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge HCLK);
    #1;
    check_all();
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d, input bit good);
    YDATA[ch*DW +: DW] = d;
    YPARITY[ch] = good ? good_par(d, PARTYSEL) : ~good_par(d, PARTYSEL);
  endtask

  task automatic do_xfer(input int ch, input logic [DW-1:0] d, input bit good);
    set_ch(ch, d, good);
    YREQ = '0;
    YREQ[ch] = 1'b1;
    cycle();
    OACK = 1;
    cycle();
    OACK = 0;
    YREQ = '0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants[$];
    int hi;
    logic prev_oreq;

    HRESET = 1; PARTYSEL = 0; OACK = 0; YREQ = '0; YDATA = '0; YPARITY = '0;
    cycle();
    cycle();
    chk("rst_oreq", 64'(OREQ), 64'(0));
    chk("rst_yack", 64'(YACK), 64'(0));
    chk("rst_odata", 64'(ODATA), 64'(0));
    chk("rst_osrc", 64'(OSRC), 64'(0));
    chk("rst_parerr", 64'(PARERR), 64'(0));
    chk("rst_errcnt", 64'(ERRCNT), 64'(0));
    HRESET = 0;

    // Single request on channel 2.
    set_ch(2, 32'h0000_0001, 1);
    YREQ = 4'b0100;
    cycle();
    chk("t1_oreq", 64'(OREQ), 64'(1));
    chk("t1_odata", 64'(ODATA), 64'h1);
    chk("t1_osrc", 64'(OSRC), 64'(2));
    chk("t1_parerr", 64'(PARERR), 64'(0));
    cycle();
    OACK = 1;
    cycle();
    chk("t1_yack", 64'(YACK), 64'b0100);
    chk("t1_oreq_low", 64'(OREQ), 64'(0));
    YREQ = '0; OACK = 0;
    cycle();
    chk("t1_yack_low", 64'(YACK), 64'(0));

    // Slow release: source holds YREQ after YACK; a second requester must wait.
    set_ch(1, 32'hA5A5_0F0F, 1);
    YREQ = 4'b0010;
    cycle();
    chk("slow_osrc", 64'(OSRC), 64'(1));
    OACK = 1;
    cycle();
    OACK = 0;
    set_ch(0, 32'h0000_00F1, 1);
    YREQ = 4'b0011;
    repeat (5) begin
      cycle();
      chk("slow_yack_hold", 64'(YACK), 64'b0010);
      chk("slow_no_grant", 64'(OREQ), 64'(0));
    end
    YREQ = 4'b0001;
    cycle();
    chk("slow_yack_drop", 64'(YACK), 64'(0));
    chk("slow_no_b2b", 64'(OREQ), 64'(0));
    cycle();
    chk("slow_regrant", 64'(OREQ), 64'(1));
    chk("slow_regrant_src", 64'(OSRC), 64'(0));
    OACK = 1;
    cycle();
    OACK = 0; YREQ = '0;
    cycle();

    // Granted channel changes its data during XFER.
    set_ch(3, 32'hDEAD_BEEF, 1);
    YREQ = 4'b1000;
    cycle();
    YDATA[3*DW +: DW] = 32'h1234_5678;
    repeat (3) begin
      cycle();
      chk("stab_odata", 64'(ODATA), 64'hDEAD_BEEF);
    end
    OACK = 1;
    cycle();
    OACK = 0; YREQ = '0;
    cycle();

    // Parity error with odd sense, then saturation of the counter.
    PARTYSEL = 1;
    YDATA[0 +: DW] = 32'hFFFF_FFFF;
    YPARITY[0] = 1'b0;
    YREQ = 4'b0001;
    cycle();
    chk("perr_pulse", 64'(PARERR), 64'(1));
    chk("perr_cnt", 64'(ERRCNT), 64'(1));
    chk("perr_odata", 64'(ODATA), 64'hFFFF_FFFF);
    chk("perr_opar", 64'(OPARITY), 64'(0));
    cycle();
    chk("perr_pulse_end", 64'(PARERR), 64'(0));
    OACK = 1;
    cycle();
    OACK = 0; YREQ = '0;
    cycle();
    for (int i = 0; i < 299; i++) do_xfer(i % N, $urandom, 0);
    chk("errcnt_sat", 64'(ERRCNT), 64'(255));
    PARTYSEL = 0;

    // Reset during XFER, then reset during RELEASE.
    set_ch(3, 32'h3333_0003, 1);
    set_ch(1, 32'h1111_0001, 1);
    YREQ = 4'b1010;
    cycle();
    HRESET = 1;
    cycle();
    chk("rstx_oreq", 64'(OREQ), 64'(0));
    chk("rstx_yack", 64'(YACK), 64'(0));
    chk("rstx_errcnt", 64'(ERRCNT), 64'(0));
    HRESET = 0;
    YREQ = 4'b1000;
    cycle();
    chk("rstx_regrant", 64'(OREQ), 64'(1));
    chk("rstx_regrant_src", 64'(OSRC), 64'(3));
    OACK = 1;
    cycle();
    OACK = 0; YREQ = '0;
    cycle();
    do_xfer(2, 32'h2222_0002, 1);
    YREQ = 4'b1000;
    cycle();
    OACK = 1;
    cycle();
    chk("rstr_in_release", 64'(YACK), 64'b1000);
    HRESET = 1; OACK = 0;
    cycle();
    chk("rstr_yack", 64'(YACK), 64'(0));
    chk("rstr_oreq", 64'(OREQ), 64'(0));
    HRESET = 0;
    set_ch(0, 32'h0000_0A0A, 1);
    YREQ = 4'b1001;
    cycle();
    chk("rstr_ptr_zero", 64'(OSRC), 64'(0));
    OACK = 1;
    cycle();
    OACK = 0; YREQ = '0;
    cycle();

    // All four channels requesting continuously; consumer acks after two cycles.
    HRESET = 1;
    cycle();
    HRESET = 0;
    for (int i = 0; i < N; i++) set_ch(i, $urandom, 1);
    YREQ = '1;
    OACK = 0;
    hi = 0;
    for (int c = 0; c < 60 && grants.size() < 5; c++) begin
      prev_oreq = OREQ;
      cycle();
      if (OREQ && !prev_oreq) grants.push_back(int'(OSRC));
      hi = OREQ ? hi + 1 : 0;
      OACK = OREQ && (hi >= 2);
      for (int i = 0; i < N; i++) YREQ[i] = !YACK[i];
    end
    chk("rr_count", 64'(grants.size()), 64'(5));
    for (int k = 0; k < 5; k++)
      chk("rr_seq", 64'((k < grants.size()) ? grants[k] : 99), 64'(k % N));

    // Randomized traffic with occasional resets and parity-sense flips.
    for (int c = 0; c < 600; c++) begin
      cycle();
      HRESET = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) PARTYSEL = ~PARTYSEL;
      for (int i = 0; i < N; i++) begin
        if (!YREQ[i] && !YACK[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_ch(i, $urandom, $urandom_range(0, 3) != 0);
            YREQ[i] = 1'b1;
          end
        end else if (YREQ[i] && YACK[i]) begin
          if ($urandom_range(0, 1) == 0) YREQ[i] = 1'b0;
        end else if (OREQ && int'(OSRC) == i && $urandom_range(0, 3) == 0) begin
          YDATA[i*DW +: DW] = $urandom;
        end
      end
      if (OREQ) OACK = OACK | ($urandom_range(0, 2) == 0);
      else if (OACK) OACK = ($urandom_range(0, 1) == 0);
    end
    HRESET = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
